edge_scan_ctrl: RTL

Readout sequencer for the 4096-bit sticky edge-mask accumulator. On a start command it walks the accumulator's 32-bit readout mux (sel1 bank, sel2 word) over all 128 words and streams each word out on a valid/ready interface. It can optionally skip all-zero words, and can clear the accumulator once the scan finishes. It sits between the accumulator and the host-side readout path, and is the only driver of the accumulator's select lines and reset.

---
 rtl/edge_scan_ctrl_if.sv | 23 ++
 rtl/edge_scan_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/edge_scan_ctrl_if.sv
// Readout stream between the edge-scan sequencer and the host-side path.
// No storage here; latency is whatever the producer adds.
// Valid/ready: the master holds data and index stable until ready is seen.
interface edge_scan_ctrl_if;
  logic [31:0] out_data;
  logic [6:0]  out_idx;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output out_data,
    output out_idx,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_idx,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/edge_scan_ctrl.sv
// Walks the 128-word sticky edge-mask readout mux and streams each word out, optional zero skip and post-scan clear.
// Start to first valid in 2 cycles; 2 cycles per emitted word, 1 per skipped word, CLR_CYCLES extra for clear.
// Stalls in OUT while out_ready is low with data/index held; abort or reset are the only ways to drop a word.
module edge_scan_ctrl #(
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic                   CLK,
  input  logic                   RST_n,
  input  logic                   start,
  input  logic                   skip_zero,
  input  logic                   clr_after,
  input  logic                   abort,
  output logic [2:0]             sel1,
  output logic [7:0]             sel2,
  input  logic [31:0]            result_imp,
  output logic                   acc_clr_n,
  edge_scan_ctrl_if.master       rd,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             nz_cnt
);

  // Down-counter load value: CLR counts CLR_CYCLES-1 down to 0 inclusive.
  localparam logic [3:0] CLR_LOAD = 4'(CLR_CYCLES - 1);
  localparam logic [6:0] LAST_IDX = 7'd127;

  // The END decision from the scan description takes no cycle, so it is
  // folded into the SEL/OUT transitions rather than given its own state.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEL  = 3'd1,
    S_OUT  = 3'd2,
    S_CLR  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  idx_q, idx_d;
  logic [7:0]  nz_q, nz_d;
  logic        skip_q, skip_d;
  logic        clr_q, clr_d;
  logic [3:0]  clr_cnt_q, clr_cnt_d;
  logic [31:0] data_q;
  logic [6:0]  oidx_q;
  logic        cap;
  logic        end_scan;

  // State register; reset lands in IDLE so no clear is ever issued by a reset.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control; abort overrides every other transition.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nz_d      = nz_q;
    skip_d    = skip_q;
    clr_d     = clr_q;
    clr_cnt_d = clr_cnt_q;
    cap       = 1'b0;
    end_scan  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          skip_d  = skip_zero;
          clr_d   = clr_after;
          idx_d   = 7'd0;
          nz_d    = 8'd0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        // The select lines were registered last cycle, so result_imp is settled.
        cap = 1'b1;
        if (skip_q && (result_imp == 32'd0)) begin
          if (idx_q == LAST_IDX) begin
            end_scan = 1'b1;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (rd.out_ready) begin
          nz_d = nz_q + 8'd1;
          if (idx_q == LAST_IDX) begin
            end_scan = 1'b1;
          end else begin
            idx_d   = idx_q + 7'd1;
            state_d = S_SEL;
          end
        end
      end
      S_CLR: begin
        if (clr_cnt_q == 4'd0) begin
          state_d = S_DONE;
        end else begin
          clr_cnt_d = clr_cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (end_scan) begin
      if (clr_q) begin
        state_d   = S_CLR;
        clr_cnt_d = CLR_LOAD;
      end else begin
        state_d = S_DONE;
      end
    end

    // A word in flight when abort arrives is not counted, even if ready was high.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      nz_d    = nz_q;
      idx_d   = idx_q;
    end
  end

  // Scan counter, select lines, latched modes and the captured output word.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      idx_q     <= 7'd0;
      sel1      <= 3'd0;
      sel2      <= 8'd0;
      nz_q      <= 8'd0;
      skip_q    <= 1'b0;
      clr_q     <= 1'b0;
      clr_cnt_q <= 4'd0;
      data_q    <= 32'd0;
      oidx_q    <= 7'd0;
    end else begin
      idx_q     <= idx_d;
      // Registered from idx_d so the mux already shows the new word in SEL.
      sel1      <= idx_d[6:4];
      sel2      <= {4'b0000, idx_d[3:0]};
      nz_q      <= nz_d;
      skip_q    <= skip_d;
      clr_q     <= clr_d;
      clr_cnt_q <= clr_cnt_d;
      if (cap) begin
        data_q <= result_imp;
        oidx_q <= idx_q;
      end
    end
  end

  assign rd.out_valid = (state_q == S_OUT);
  assign rd.out_data  = data_q;
  assign rd.out_idx   = oidx_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign acc_clr_n    = (state_q != S_CLR);
  assign nz_cnt       = nz_q;

  // A stalled word must stay put until accepted or the scan is abandoned.
  a_stall_hold: assert property (@(posedge CLK) disable iff (!RST_n)
    (state_q == S_OUT && !rd.out_ready && !abort) |=>
    (state_q == S_OUT && $stable(data_q) && $stable(oidx_q)));

  // The mux selects always mirror the word counter.
  a_sel_map: assert property (@(posedge CLK)
    ({sel1, sel2[3:0]} == idx_q) && (sel2[7:4] == 4'd0));

endmodule
